kernel_mhsa_mul_pipe: RTL

Parametrised, pipelined multiplier / multiply-accumulate for the MHSA kernel datapath (Q·K score and P·V products). It generalises the fixed single-cycle unsigned×signed multiplier with configurable operand widths and signedness, NUM_STAGE register latency, valid/ready flow control, and an optional saturating accumulate mode with group-end marker. It sits between the operand fetch buffers and the score/softmax or output writeback stage.

---
 rtl/kernel_mhsa_mul_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/kernel_mhsa_mul_pipe.sv
// Purpose: pipelined A*B multiplier / saturating multiply-accumulate for the MHSA score and P*V datapath.
// Latency: NUM_STAGE cycles from accepted beat to dout; ACC_EN=1 emits one result per in_last-terminated group.
// Backpressure: one global enable (ce = !out_valid | out_ready) freezes every stage; in_ready = ce.
//
// Ports:
//   ap_clk, ap_rst_n           clock, async active-low reset
//   in_valid/in_ready          operand handshake, din0 (A), din1 (B), in_last (group end, ACC_EN=1 only)
//   out_valid/out_ready        result handshake, dout (product or group sum), out_ovf (saturated)
module kernel_mhsa_mul_pipe #(
    parameter int DIN0_WIDTH  = 22,
    parameter int DIN1_WIDTH  = 21,
    parameter int DOUT_WIDTH  = 43,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 1,
    parameter int NUM_STAGE   = 3,
    parameter int ACC_EN      = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  out_ovf
);

    localparam int P = DIN0_WIDTH + DIN1_WIDTH;
    // Two guard bits above the wider of product/result: the exact product and
    // acc+product both fit, so saturation can be decided by plain signed compares.
    localparam int W = ((P > DOUT_WIDTH) ? P : DOUT_WIDTH) + 2;
    localparam bit RES_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

    localparam logic signed [W-1:0] ONE_W   = {{(W-1){1'b0}}, 1'b1};
    localparam logic signed [W-1:0] SAT_MAX = RES_SIGNED ? (ONE_W <<< (DOUT_WIDTH-1)) - ONE_W
                                                         : (ONE_W <<< DOUT_WIDTH) - ONE_W;
    localparam logic signed [W-1:0] SAT_MIN = RES_SIGNED ? -(ONE_W <<< (DOUT_WIDTH-1))
                                                         : {W{1'b0}};

    logic ce;
    assign ce       = !out_valid || out_ready;
    assign in_ready = ce;

    // Operand extension by signedness, then one signed multiply at full width.
    logic                  a_msb;
    logic                  b_msb;
    logic signed [W-1:0]   a_w;
    logic signed [W-1:0]   b_w;
    logic signed [W-1:0]   prod_in;

    assign a_msb   = (DIN0_SIGNED != 0) ? din0[DIN0_WIDTH-1] : 1'b0;
    assign b_msb   = (DIN1_SIGNED != 0) ? din1[DIN1_WIDTH-1] : 1'b0;
    assign a_w     = {{(W-DIN0_WIDTH){a_msb}}, din0};
    assign b_w     = {{(W-DIN1_WIDTH){b_msb}}, din1};
    assign prod_in = a_w * b_w;

    // Product pipeline: NUM_STAGE-1 register stages, the output register is the last one.
    logic                fin_vld;
    logic                fin_last;
    logic signed [W-1:0] fin_prod;

    generate
        if (NUM_STAGE > 1) begin : g_pipe
            localparam int D = NUM_STAGE - 1;
            logic [D-1:0]        vld_q;
            logic [D-1:0]        last_q;
            logic signed [W-1:0] prod_q [D];

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    vld_q  <= '0;
                    last_q <= '0;
                    for (int s = 0; s < D; s++) prod_q[s] <= '0;
                end else if (ce) begin
                    // in_ready == ce, so in_valid here is exactly "beat accepted"
                    vld_q[0]  <= in_valid;
                    last_q[0] <= in_last;
                    prod_q[0] <= prod_in;
                    for (int s = 1; s < D; s++) begin
                        vld_q[s]  <= vld_q[s-1];
                        last_q[s] <= last_q[s-1];
                        prod_q[s] <= prod_q[s-1];
                    end
                end
            end

            assign fin_vld  = vld_q[D-1];
            assign fin_last = last_q[D-1];
            assign fin_prod = prod_q[D-1];
        end else begin : g_nopipe
            assign fin_vld  = in_valid;
            assign fin_last = in_last;
            assign fin_prod = prod_in;
        end
    endgenerate

    // Final stage: optional accumulate, then clip to the dout range.
    logic [DOUT_WIDTH-1:0] acc;
    logic                  grp_ovf;
    logic signed [W-1:0]   acc_w;
    logic signed [W-1:0]   sum_w;
    logic [DOUT_WIDTH-1:0] sat_d;
    logic                  sat_ovf;

    assign acc_w = {{(W-DOUT_WIDTH){RES_SIGNED & acc[DOUT_WIDTH-1]}}, acc};

    always_comb begin
        sum_w   = (ACC_EN != 0) ? (acc_w + fin_prod) : fin_prod;
        sat_d   = sum_w[DOUT_WIDTH-1:0];
        sat_ovf = 1'b0;
        if (sum_w > SAT_MAX) begin
            sat_d   = SAT_MAX[DOUT_WIDTH-1:0];
            sat_ovf = 1'b1;
        end else if (sum_w < SAT_MIN) begin
            sat_d   = SAT_MIN[DOUT_WIDTH-1:0];
            sat_ovf = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            out_ovf   <= 1'b0;
            acc       <= '0;
            grp_ovf   <= 1'b0;
        end else if (ce) begin
            if (ACC_EN == 0) begin
                out_valid <= fin_vld;
                if (fin_vld) begin
                    dout    <= sat_d;
                    out_ovf <= sat_ovf;
                end
            end else begin
                out_valid <= fin_vld && fin_last;
                if (fin_vld) begin
                    if (fin_last) begin
                        // Clearing here lets the next group start on the very next beat.
                        dout    <= sat_d;
                        out_ovf <= grp_ovf | sat_ovf;
                        acc     <= '0;
                        grp_ovf <= 1'b0;
                    end else begin
                        acc     <= sat_d;
                        grp_ovf <= grp_ovf | sat_ovf;
                    end
                end
            end
        end
    end

endmodule
